// File: rtl/config_pkg.sv
// ---------------------------------------------------------------------------
// config_pkg
// Shared definitions for the configuration sequencer: module-id constants
// decoded by the tile address matchers, address field bounds, the request
// record buffered in the FIFO, the sequencer state enum and the module-id
// validity helper.
// ---------------------------------------------------------------------------
package config_pkg;

   localparam logic [15:0] MOD_NONE = 16'd0;
   localparam logic [15:0] MOD_CLB  = 16'd4;
   localparam logic [15:0] MOD_CB1  = 16'd5;
   localparam logic [15:0] MOD_CB0  = 16'd6;
   localparam logic [15:0] MOD_SB   = 16'd7;

   localparam int TILE_ID_LSB = 0;
   localparam int TILE_ID_MSB = 15;
   localparam int MOD_ID_LSB  = 16;
   localparam int MOD_ID_MSB  = 31;

   // One buffered write request; packed so it can travel through a plain FIFO.
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        last;
   } cfg_req_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } seq_state_e;

   // True when the module id names a module that some tile matcher decodes.
   function automatic logic is_valid_mod(input logic [15:0] mod_id);
      is_valid_mod = (mod_id == MOD_CLB) || (mod_id == MOD_CB1) ||
                     (mod_id == MOD_CB0) || (mod_id == MOD_SB);
   endfunction

endpackage

// File: rtl/config_sequencer_if.sv
// ---------------------------------------------------------------------------
// config_sequencer_if
// Valid/ready request stream into the configuration sequencer.
//   in_valid : request present          (master -> slave)
//   in_ready : buffer can accept        (slave  -> master)
//   in_addr  : [15:0] tile id, [31:16] module id
//   in_data  : configuration word
//   in_last  : final request of a stream
// ---------------------------------------------------------------------------
interface config_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic        in_last;

   modport master (output in_valid, in_addr, in_data, in_last, input in_ready);
   modport slave  (input in_valid, in_addr, in_data, in_last, output in_ready);
endinterface

// File: rtl/config_fifo.sv
// ---------------------------------------------------------------------------
// config_fifo
// Synchronous FIFO, DEPTH entries (power of two, >= 2) of WIDTH bits.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push_i     : write wdata_i (ignored when full)
//   pop_i      : discard head entry (ignored when empty)
//   rdata_o    : head entry, valid while !empty_o
//   full_o     : DEPTH entries held (from registered occupancy)
//   empty_o    : no entries held
// ---------------------------------------------------------------------------
module config_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 65
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign push_ok_s = push_i & ~full_o;
   assign pop_ok_s  = pop_i & ~empty_o;
   assign rdata_o   = mem_q[rd_ptr_q];

   // Storage array: written on accepted push, never reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leaves occupancy unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/config_sequencer.sv
// ---------------------------------------------------------------------------
// config_sequencer
// Buffers {addr, data, last} write requests and issues each as a one-cycle
// write on the shared config_addr/config_data bus, with GAP_CYCLES null
// cycles after each write. Requests naming no tile module are dropped.
//   clk, reset   : clock, synchronous active-high reset
//   req          : request stream (slave side)
//   config_addr  : registered bus address, 0 when idle/gap
//   config_data  : registered bus data, 0 when idle/gap
//   busy         : buffer non-empty or sequencer not idle
//   done         : one-cycle pulse when a last-flagged entry completes
//   err_bad_mod  : sticky, set when an entry is rejected
//   write_count  : issued writes since reset, saturating
// ---------------------------------------------------------------------------
module config_sequencer
   import config_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   config_sequencer_if.slave    req,
   output logic [31:0]          config_addr,
   output logic [31:0]          config_data,
   output logic                 busy,
   output logic                 done,
   output logic                 err_bad_mod,
   output logic [15:0]          write_count
);
   seq_state_e  state_q, state_d;
   logic [3:0]  gap_cnt_q, gap_cnt_d;
   logic        last_q, last_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [15:0] wcnt_q, wcnt_d;

   logic        full_s, empty_s, push_s, pop_s, decide_s;
   logic [$bits(cfg_req_t)-1:0] head_bits_s;
   cfg_req_t    head_s;

   // in_ready is held low in the reset cycle itself, not just after it.
   assign req.in_ready = ~full_s & ~reset;
   assign push_s       = req.in_valid & req.in_ready;
   assign head_s       = cfg_req_t'(head_bits_s);

   config_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(cfg_req_t))
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_s),
      .wdata_i ({req.in_addr, req.in_data, req.in_last}),
      .pop_i   (pop_s),
      .rdata_o (head_bits_s),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   // Next-state logic: the last gap cycle (or ISSUE when there is no gap)
   // takes the same pop decision as IDLE so writes stay 1+GAP_CYCLES apart.
   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      last_d    = last_q;
      addr_d    = 32'd0;
      data_d    = 32'd0;
      done_d    = 1'b0;
      err_d     = err_q;
      wcnt_d    = wcnt_q;
      pop_s     = 1'b0;
      decide_s  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            decide_s = 1'b1;
         end
         ST_ISSUE: begin
            if (GAP_CYCLES == 0) begin
               decide_s = 1'b1;
               done_d   = last_q;
            end else begin
               state_d   = ST_GAP;
               gap_cnt_d = 4'(GAP_CYCLES);
            end
         end
         ST_GAP: begin
            if (gap_cnt_q <= 4'd1) begin
               decide_s = 1'b1;
               done_d   = last_q;
            end else begin
               gap_cnt_d = gap_cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (decide_s) begin
         state_d = ST_IDLE;
         last_d  = 1'b0;
         if (!empty_s) begin
            pop_s = 1'b1;
            if (is_valid_mod(head_s.addr[MOD_ID_MSB:MOD_ID_LSB])) begin
               state_d = ST_ISSUE;
               addr_d  = head_s.addr;
               data_d  = head_s.data;
               last_d  = head_s.last;
               if (wcnt_q != 16'hFFFF) begin
                  wcnt_d = wcnt_q + 16'd1;
               end else begin
                  wcnt_d = wcnt_q;
               end
            end else begin
               // Rejected entry: bus stays null, done fires now if it ended a stream.
               err_d  = 1'b1;
               done_d = done_d | head_s.last;
            end
         end else begin
            pop_s = 1'b0;
         end
      end else begin
         pop_s = 1'b0;
      end
   end

   // State and registered bus/status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         gap_cnt_q <= 4'd0;
         last_q    <= 1'b0;
         addr_q    <= 32'd0;
         data_q    <= 32'd0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         wcnt_q    <= 16'd0;
      end else begin
         state_q   <= state_d;
         gap_cnt_q <= gap_cnt_d;
         last_q    <= last_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         done_q    <= done_d;
         err_q     <= err_d;
         wcnt_q    <= wcnt_d;
      end
   end

   assign config_addr = addr_q;
   assign config_data = data_q;
   assign done        = done_q;
   assign err_bad_mod = err_q;
   assign write_count = wcnt_q;
   assign busy        = ~empty_s | (state_q != ST_IDLE);
endmodule

// File: doc/config_sequencer.md
# config_sequencer

Single-master configuration sequencer feeding the shared `config_addr`/`config_data` bus that every tile's address matchers decode. It accepts {address, data} write requests over a valid/ready stream, buffers them, and issues each as a one-cycle bus write. Between writes it drives a null address so that no CLB, connect box or switch box enable ever stays asserted longer than one cycle. It also rejects writes whose module field names no tile module.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: request buffer entries; power of two, ≥2.
- `GAP_CYCLES`, 1: null-address cycles inserted after each issued write; 0..15.

Ports:
- `clk`  in  1: sole clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: request present.
- `in_ready`  out  1: buffer can accept; transfer when `in_valid & in_ready` at a rising edge.
- `in_addr`  in  32: [15:0] tile id, [31:16] module id.
- `in_data`  in  32: configuration word.
- `in_last`  in  1: final request of a stream.
- `config_addr`  out  32: bus address, registered.
- `config_data`  out  32: bus data, registered.
- `busy`  out  1: buffer non-empty or FSM not IDLE.
- `done`  out  1: one-cycle pulse at stream completion.
- `err_bad_mod`  out  1: sticky; set on a rejected request.
- `write_count`  out  16: issued writes since reset; saturates at 0xFFFF.

## Operation
- Valid module ids: 4 (CLB), 5 (CB1), 6 (CB0), 7 (SB). Null module id: 0. No matcher responds to the null id.
- Buffer: FIFO of `FIFO_DEPTH` entries {addr, data, last}. `in_ready = !full`, computed from the registered occupancy. A pop in the same cycle does not raise `in_ready`.
- FSM states: IDLE, ISSUE, GAP.
- IDLE, buffer empty: stay in IDLE. Drive `config_addr = 0`, `config_data = 0`.
- IDLE, head entry valid module: pop the entry and go to ISSUE. Load `config_addr`/`config_data` from the entry. Increment `write_count` (saturating).
- IDLE, head entry invalid module: pop the entry, set `err_bad_mod`, stay in IDLE. Bus stays null.
- ISSUE, lasting exactly one cycle: bus carries the write.
  - If `GAP_CYCLES > 0`, go to GAP and load the gap counter with `GAP_CYCLES`.
  - If `GAP_CYCLES = 0`, behave as IDLE: a valid head entry is issued back-to-back in the next cycle.
- GAP: bus null. Decrement the counter; go to IDLE when it reaches 1.
- `done`:
  - pulses for one cycle when the FSM returns to IDLE after completing an entry with `last = 1`;
  - for a rejected last entry, pulses in the cycle after the pop.
- `err_bad_mod` clears only on reset.
- Arithmetic: the gap counter is 4 bits; `write_count` is 16 bits and saturates, no wrap.

## Timing
- Reset, one cycle: next state has FIFO empty, FSM IDLE, and `config_addr`, `config_data`, `done`, `err_bad_mod`, `write_count`, `busy` all 0. `in_ready` is 0 during the reset cycle and 1 from the following cycle.
- Reset mid-operation:
  - buffered entries are discarded;
  - a write on the bus completes its current cycle only;
  - the bus is null the cycle after reset.
- Latency: a request accepted at edge k into an empty buffer with FSM idle appears on the bus during the cycle after edge k+1, i.e., two cycles later.
- Throughput: one write per `1 + GAP_CYCLES` cycles. A rejected entry costs one cycle.
- Push and pop in the same cycle: both take effect; occupancy is unchanged.
- Full buffer: `in_valid` is held off; no entry is dropped or overwritten.
- The bus is never non-null for two consecutive cycles unless `GAP_CYCLES = 0`.

## Structure
- Shared package `config_pkg`:
  - constants `MOD_NONE = 0`, `MOD_CLB = 4`, `MOD_CB1 = 5`, `MOD_CB0 = 6`, `MOD_SB = 7`;
  - field bounds `TILE_ID_LSB = 0`, `TILE_ID_MSB = 15`, `MOD_ID_LSB = 16`, `MOD_ID_MSB = 31`;
  - FSM state enum;
  - function `is_valid_mod`.
- Sub-module `config_fifo`: parameterised synchronous FIFO providing full, empty, push and pop. The FSM lives in `config_sequencer`.

## Test plan
- Reset, then push {0x0005_0003, 0x5}, last=1, with `GAP_CYCLES = 1`:
  - bus shows 0x0005_0003/0x5 for exactly one cycle, two cycles after acceptance;
  - then null; `done` pulses one cycle after the gap; `write_count` = 1.
- Push 6 valid requests back-to-back with `FIFO_DEPTH = 4`, `GAP_CYCLES = 2`:
  - `in_ready` drops at 4 entries;
  - all 6 are issued in order, 3 cycles apart;
  - no write is lost or duplicated.
- Push {0x0009_0001} then valid {0x0007_0001}:
  - the first is dropped with `err_bad_mod` = 1 and the bus null;
  - the second is issued one cycle later;
  - `write_count` = 1.
- `GAP_CYCLES = 0`, 3 valid requests preloaded: bus carries 3 consecutive non-null cycles.
- Assert `reset` while 3 entries are buffered and the bus is mid-gap: bus null next cycle, `busy` = 0, no further writes issued, `write_count` = 0.
- Stream whose last entry has module 2:
  - entry rejected and `err_bad_mod` set;
  - `done` still pulses once.
